// File: rtl/dm_access_ctrl.sv
// Multi-cycle data-memory access controller: holds a captured MEM-stage request on the
// DM SRAM for LAT cycles, stalls the pipeline meanwhile, and returns a registered read word.
module dm_access_ctrl #(
  parameter int LAT    = 1,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              flush,
  input  logic [3:0]        web_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       di_in,
  output logic              stall,
  output logic              DM_CS,
  output logic              DM_OE,
  output logic [3:0]        DM_WEB,
  output logic [ADDR_W-1:0] DM_A,
  output logic [31:0]       DM_DI,
  input  logic [31:0]       DM_DO,
  output logic [31:0]       rdata,
  output logic              rdata_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       di_q, di_d;
  logic [3:0]        web_q, web_d;
  logic              rd_q, rd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req;

  assign req = (req_read | req_write) & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      di_q    <= 32'd0;
      web_q   <= 4'b1111;
      rd_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      web_q   <= web_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    di_d    = di_q;
    web_d   = web_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr_in;
          di_d    = di_in;
          // A simultaneous read+write request is resolved as a write.
          rd_d    = req_read & ~req_write;
          web_d   = req_write ? web_in : 4'b1111;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (rd_q) rdata_d = DM_DO;
          state_d = DONE;
        end
      end
      DONE: begin
        // The same instruction is still in EX/MEM here, so req is not looked at.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DM_CS  = 1'b0;
    DM_OE  = 1'b0;
    DM_WEB = 4'b1111;
    if (state_q == BUSY) begin
      DM_CS  = 1'b1;
      DM_OE  = rd_q;
      DM_WEB = web_q;
    end
  end

  assign DM_A        = addr_q;
  assign DM_DI       = di_q;
  assign stall       = ((state_q == IDLE) & req) | (state_q == BUSY);
  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == DONE) & rd_q;

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Multi-cycle data-memory access controller that sits directly downstream of the MEM stage, between the core and the DM SRAM. It takes the MEM stage's byte-write enables, word address, and aligned write data. It holds the request stable on the SRAM for a parameterised number of cycles, stalls the pipeline while the access is in flight, and returns a registered read word to the load sign-extension path in WB.

## Interface
Parameters:
- LAT, 1: SRAM access cycles per request; legal range 1..7.
- ADDR_W, 14: word-address width.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_read  in  1  MEM-stage memread.
- req_write  in  1  MEM-stage memwrite.
- flush  in  1  cancels a not-yet-accepted request.
- web_in  in  4  active-low byte write enables; 4'b1111 means no byte written.
- addr_in  in  ADDR_W  word address.
- di_in  in  32  byte-lane-aligned write data.
- stall  out  1  freezes PC and IF/ID, ID/EX, EX/MEM; combinational.
- DM_CS  out  1  SRAM chip select.
- DM_OE  out  1  SRAM output enable.
- DM_WEB  out  4  SRAM byte write enables, active-low.
- DM_A  out  ADDR_W  SRAM address.
- DM_DI  out  32  SRAM write data.
- DM_DO  in  32  SRAM read data.
- rdata  out  32  registered read word to WB.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - BUSY: SRAM driven from captured registers; down-counter cnt (3 bits) active.
  - DONE: one-cycle release of the pipeline.
- Request: req = (req_read | req_write) & ~flush.
- IDLE:
  - With req: capture addr_in, di_in, kind, and captured web.
    - Captured web = web_in for a write, 4'b1111 for a read.
    - cnt <= LAT-1.
    - Next state BUSY.
  - Without req: stay in IDLE; capture registers keep their values.
- BUSY:
  - Outputs:
    - DM_CS=1.
    - DM_OE = (kind==read).
    - DM_WEB = captured web.
    - DM_A, DM_DI = captured values.
  - cnt>0: decrement cnt; stay in BUSY.
  - cnt==0 and kind==read: rdata <= DM_DO; next state DONE.
  - cnt==0 and kind==write: rdata unchanged; next state DONE.
- DONE:
  - SRAM outputs return to idle values.
  - rdata_valid=1 only if the access was a read.
  - req is ignored; this is the same instruction still in EX/MEM, since the pipeline advances at the end of DONE.
  - Next state IDLE.
- Idle values for SRAM outputs (IDLE and DONE):
  - DM_CS=0, DM_OE=0, DM_WEB=4'b1111.
  - DM_A, DM_DI hold the last captured value.
- stall = (IDLE & req) | BUSY; stall is 0 in DONE.
- Simultaneous req_read & req_write is illegal; it is handled as a write, and rdata is not updated.
- req_write with web_in=4'b1111: the full sequence runs with no byte written.
- flush:
  - In IDLE: suppresses capture; stall stays 0.
  - In BUSY or DONE: ignored; an accepted access always completes.
- rdata holds its value until the next completed read.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - DM_CS=0, DM_OE=0, DM_WEB=4'b1111, DM_A=0, DM_DI=0.
  - rdata=0, rdata_valid=0.
  - stall is 0 unless req is present.
- Reset asserted mid-BUSY aborts the access immediately; a write may be partially applied, which is accepted.
- Deassertion is synchronised externally; the first edge after release is a normal IDLE cycle.
- Access latency: request cycle T0 (IDLE), then BUSY for T1..T_LAT, then DONE at T_LAT+1.
  - stall is high for T0..T_LAT, i.e. LAT+1 cycles.
  - DM_DO is sampled at the edge ending T_LAT.
  - rdata and rdata_valid are visible in T_LAT+1.
- For a write, DM_WEB is low for exactly LAT consecutive cycles.
- Back-to-back memory instructions: the next request is first seen in the IDLE cycle after DONE, so accesses occur at most once every LAT+2 cycles.

## Test plan
- LAT=1; read at addr_in=14'h0010 with DM_DO=32'hDEADBEEF:
  - stall=1 for 2 cycles.
  - DM_CS=1 and DM_OE=1 in one cycle.
  - Next cycle: rdata=32'hDEADBEEF, rdata_valid=1, stall=0.
- LAT=3; sb-style write with web_in=4'b1101, di_in=32'h0000AB00, addr_in=14'h0004:
  - DM_WEB=4'b1101 for exactly 3 cycles.
  - stall high for 4 cycles.
  - rdata unchanged; rdata_valid=0.
- Back-to-back read then write (LAT=2):
  - The second request is not accepted in the first access's DONE cycle.
  - The second access starts in the following IDLE cycle.
  - Total stall cycles = 3+3.
- flush=1 with req_read=1 in IDLE: no capture, DM_CS stays 0, stall=0. flush=1 during BUSY: the access completes normally.
- rst pulled low in the second BUSY cycle of a LAT=3 read, with rdata holding a nonzero value from a previous read:
  - Same cycle: DM_CS=0, DM_WEB=4'b1111, rdata=0, stall=0.
  - After release, a fresh read completes correctly.
- req_read=req_write=1 with web_in=4'b0000: treated as a write; DM_OE=0; rdata_valid never asserts.
